// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data-memory responder on the far side of the Memory stage.
//   It accepts one load or store at a time and backs it with a word-addressed
//   RAM of 2**ADDR_BITS 16-bit words. After acceptance it inserts WAIT_CYCLES
//   busy cycles, holding the pipeline with Stall. It then signals completion
//   with a one-cycle Done pulse. Loads also get a one-cycle RdValid pulse.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   ReqEn    in   access request, held by the requester while Stall is high
//   ReqWr    in   1 = store, 0 = load (sampled with ReqEn)
//   ReqAddr  in   word address; only [ADDR_BITS-1:0] is decoded (aliasing)
//   ReqData  in   store data
//   Stall    out  pipeline hold (combinational from state and ReqEn)
//   RdData   out  registered load result, held until the next load completes
//   RdValid  out  one-cycle pulse when RdData carries a new load result
//   Done     out  one-cycle pulse on completion of any access
module data_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqEn,
    input  logic        ReqWr,
    input  logic [15:0] ReqAddr,
    input  logic [15:0] ReqData,
    output logic        Stall,
    output logic [15:0] RdData,
    output logic        RdValid,
    output logic        Done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic [15:0]            rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   done_q, done_d;

    logic [15:0]            mem [2**ADDR_BITS];

    logic                   commit;
    logic                   commit_wr;
    logic [ADDR_BITS-1:0]   commit_addr;
    logic [15:0]            commit_data;

    // Upper address bits are deliberately ignored; addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ReqAddr[15:ADDR_BITS];

    // Commit selection. With zero wait states the access commits in the
    // acceptance cycle itself, so it must use the live request inputs
    // because nothing has been latched yet.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        commit      = 1'b0;
        commit_wr   = wr_q;
        commit_addr = addr_q;
        commit_data = data_q;
        case (state_q)
            IDLE: begin
                if (ReqEn && ZERO_WAIT) begin
                    commit      = 1'b1;
                    commit_wr   = ReqWr;
                    commit_addr = ReqAddr[ADDR_BITS-1:0];
                    commit_data = ReqData;
                end
            end
            BUSY:    commit = (cnt_q == 4'd1);
            default: commit = 1'b0;
        endcase
    end

    // Next-state and request latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (ReqEn) begin
                    wr_d    = ReqWr;
                    addr_d  = ReqAddr[ADDR_BITS-1:0];
                    data_d  = ReqData;
                    cnt_d   = WAIT_INIT;
                    state_d = ZERO_WAIT ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (commit) state_d = DONE;
            end
            // The request is still held high in DONE; it is being released,
            // not reissued, so ReqEn is ignored here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion pulses and load result, registered so they appear in DONE.
    always_comb begin
        done_d     = commit;
        rd_valid_d = commit && !commit_wr;
        rd_data_d  = (commit && !commit_wr) ? mem[commit_addr] : rd_data_q;
    end

    // Output decode.
    always_comb begin
        case (state_q)
            IDLE:    Stall = ReqEn;
            BUSY:    Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 16'h0000;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto memory macros; reset
    // only suppresses the write, which drops a store committing in that cycle.
    always_ff @(posedge clk) begin
        if (!rst && commit && commit_wr) mem[commit_addr] <= commit_data;
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Two instances are used: the default
// build (WAIT_CYCLES = 2) and a zero-wait build. Expected completions are
// queued when a request is driven and compared when Done is observed.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en, req_en0;
    logic        req_wr;
    logic [15:0] req_addr, req_data;

    logic        stall2, rd_valid2, done2;
    logic [15:0] rd_data2;
    logic        stall0, rd_valid0, done0;
    logic [15:0] rd_data0;

    typedef struct packed {
        logic        is_load;
        logic [15:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] last_rd [2];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ReqEn(req_en), .ReqWr(req_wr),
        .ReqAddr(req_addr), .ReqData(req_data), .Stall(stall2),
        .RdData(rd_data2), .RdValid(rd_valid2), .Done(done2)
    );

    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ReqEn(req_en0), .ReqWr(req_wr),
        .ReqAddr(req_addr), .ReqData(req_data), .Stall(stall0),
        .RdData(rd_data0), .RdValid(rd_valid0), .Done(done0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic o_stall(input bit sel);
        return sel ? stall0 : stall2;
    endfunction
    function automatic logic o_done(input bit sel);
        return sel ? done0 : done2;
    endfunction
    function automatic logic o_valid(input bit sel);
        return sel ? rd_valid0 : rd_valid2;
    endfunction
    function automatic logic [15:0] o_rd(input bit sel);
        return sel ? rd_data0 : rd_data2;
    endfunction

    task automatic set_en(input bit sel, input logic v);
        if (sel) req_en0 = v;
        else     req_en  = v;
    endtask

    // One complete access: request cycle, wait states, DONE, release cycle.
    // Inputs are driven 1 time unit after the edge, outputs sampled at 2.
    task automatic access(input bit sel, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input logic [15:0] exp,
                          input bit change_mid, input string tag);
        int  w;
        sb_t e;
        w = sel ? 0 : 2;
        e.is_load = !wr;
        e.data    = exp;
        sb.push_back(e);
        @(posedge clk); #1;
        set_en(sel, 1'b1);
        req_wr = wr; req_addr = addr; req_data = data;
        #1;
        for (int k = 0; k <= w; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (change_mid && k == 1) begin
                    req_addr = 16'h0006;
                    req_data = 16'h0000;
                    req_wr   = !wr;
                end
                #1;
            end
            check({tag, "/stall_busy"}, 32'(o_stall(sel)), 32'd1);
            check({tag, "/done_early"}, 32'(o_done(sel)), 32'd0);
        end
        // DONE cycle: request still held high.
        @(posedge clk); #2;
        check({tag, "/stall_done"}, 32'(o_stall(sel)), 32'd0);
        check({tag, "/done"}, 32'(o_done(sel)), 32'd1);
        e = sb.pop_front();
        check({tag, "/rd_valid"}, 32'(o_valid(sel)), 32'(e.is_load));
        if (e.is_load) last_rd[sel] = e.data;
        check({tag, "/rd_data"}, 32'(o_rd(sel)), 32'(last_rd[sel]));
        // Release cycle.
        @(posedge clk); #1;
        set_en(sel, 1'b0);
        #1;
        check({tag, "/done_clear"}, 32'(o_done(sel)), 32'd0);
        check({tag, "/valid_clear"}, 32'(o_valid(sel)), 32'd0);
        check({tag, "/stall_idle"}, 32'(o_stall(sel)), 32'd0);
        check({tag, "/rd_hold"}, 32'(o_rd(sel)), 32'(last_rd[sel]));
    endtask

    // Store on the WAIT_CYCLES=2 instance interrupted by reset in BUSY cycle
    // number busy_idx (2 is the commit cycle).
    task automatic reset_abort(input logic [15:0] addr, input logic [15:0] data,
                               input int busy_idx, input string tag);
        @(posedge clk); #1;
        req_en = 1'b1; req_wr = 1'b1; req_addr = addr; req_data = data;
        #1;
        check({tag, "/stall_req"}, 32'(stall2), 32'd1);
        for (int k = 1; k <= busy_idx; k++) begin
            @(posedge clk); #1;
            if (k == busy_idx) rst = 1'b1;
            #1;
        end
        @(posedge clk); #1;
        rst = 1'b0; req_en = 1'b0;
        #1;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        check({tag, "/stall_idle"}, 32'(stall2), 32'd0);
        check({tag, "/no_done"}, 32'(done2), 32'd0);
        check({tag, "/no_valid"}, 32'(rd_valid2), 32'd0);
        check({tag, "/rd_cleared"}, 32'(rd_data2), 32'h0000);
        @(posedge clk); #2;
        check({tag, "/no_done_later"}, 32'(done2), 32'd0);
        check({tag, "/stall_later"}, 32'(stall2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_en = 1'b0; req_en0 = 1'b0;
        req_wr = 1'b0; req_addr = 16'h0000; req_data = 16'h0000;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;

        // Reset held two cycles with no request, then one idle cycle.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst = 1'b0;
            #1;
            check("reset/stall", 32'(stall2), 32'd0);
            check("reset/rd_data", 32'(rd_data2), 32'h0000);
            check("reset/rd_valid", 32'(rd_valid2), 32'd0);
            check("reset/done", 32'(done2), 32'd0);
            check("reset/stall0", 32'(stall0), 32'd0);
        end
        @(posedge clk); #2;
        check("idle/done", 32'(done2), 32'd0);
        check("idle/rd_data", 32'(rd_data2), 32'h0000);

        // Store then load.
        access(1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, "st_beef");
        access(1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, "ld_beef");

        // Inputs changing while the access is in flight.
        access(1'b0, 1'b1, 16'h0006, 16'h1357, 16'h0000, 1'b0, "st_6");
        access(1'b0, 1'b1, 16'h0007, 16'hCAFE, 16'h0000, 1'b1, "st_7_mid");
        access(1'b0, 1'b0, 16'h0007, 16'h0000, 16'hCAFE, 1'b0, "ld_7");
        access(1'b0, 1'b0, 16'h0006, 16'h0000, 16'h1357, 1'b0, "ld_6");
        access(1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b1, "ld_5_mid");
        access(1'b0, 1'b0, 16'h0006, 16'h0000, 16'h1357, 1'b0, "ld_6_again");

        // Address aliasing on the upper bits.
        access(1'b0, 1'b1, 16'h0401, 16'hA5A5, 16'h0000, 1'b0, "st_alias");
        access(1'b0, 1'b0, 16'h0001, 16'h0000, 16'hA5A5, 1'b0, "ld_alias");
        access(1'b0, 1'b1, 16'h0000, 16'h4242, 16'h0000, 1'b0, "st_0");
        access(1'b0, 1'b0, 16'h0400, 16'h0000, 16'h4242, 1'b0, "ld_0400");

        // Reset dropping an in-flight store (first BUSY cycle, commit cycle).
        access(1'b0, 1'b1, 16'h0009, 16'h1111, 16'h0000, 1'b0, "st_9");
        reset_abort(16'h0009, 16'h7777, 1, "rst_busy1");
        access(1'b0, 1'b0, 16'h0009, 16'h0000, 16'h1111, 1'b0, "ld_9");
        access(1'b0, 1'b1, 16'h000A, 16'h2222, 16'h0000, 1'b0, "st_a");
        reset_abort(16'h000A, 16'h8888, 2, "rst_commit");
        access(1'b0, 1'b0, 16'h000A, 16'h0000, 16'h2222, 1'b0, "ld_a");

        // Zero-wait build: one Stall cycle, completion the next cycle.
        access(1'b1, 1'b1, 16'h0003, 16'h1234, 16'h0000, 1'b0, "w0_st_3");
        access(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0, "w0_ld_3");
        access(1'b1, 1'b0, 16'h0403, 16'h0000, 16'h1234, 1'b0, "w0_ld_alias");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder that sits on the far side of the processor's Memory stage.
- Accepts one load or store request at a time and backs it with an internal word-addressed RAM.
- Inserts a configurable number of wait states and holds the pipeline by driving Stall until the access completes.
- Returns load data with a one-cycle valid pulse, and signals completion of every access, load or store, with a one-cycle Done pulse.

Parameters:
- ADDR_BITS, 10, RAM depth is 2^ADDR_BITS 16-bit words; only ReqAddr[ADDR_BITS-1:0] is decoded.
- WAIT_CYCLES, 2, busy cycles inserted between request acceptance and completion; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ReqEn  input  1  access request from the Memory stage; held high by the requester while Stall is high.
- ReqWr  input  1  1 = store, 0 = load; sampled with ReqEn.
- ReqAddr  input  16  word address; upper bits are ignored, so addresses alias.
- ReqData  input  16  store data.
- Stall  output  1  pipeline hold; combinational from state and ReqEn.
- RdData  output  16  load result; registered, and holds its value until the next load completes.
- RdValid  output  1  one-cycle pulse when RdData carries a new load result.
- Done  output  1  one-cycle pulse on completion of any access.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, wait counter 0, RdData 16'h0000, RdValid 0, Done 0. Stall evaluates to ReqEn while in IDLE. RAM contents are not cleared by reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Stall = ReqEn.
  - If ReqEn = 1 at cycle T: latch ReqWr, ReqAddr[ADDR_BITS-1:0] and ReqData; load counter = WAIT_CYCLES.
  - Next state is BUSY, or DONE if WAIT_CYCLES = 0.
- BUSY:
  - Stall = 1.
  - Counter decrements every cycle. When the counter is 1, this is the commit cycle: a store writes the RAM, a load reads the RAM into RdData, and the next state is DONE.
  - BUSY occupies cycles T+1 .. T+WAIT_CYCLES.
- WAIT_CYCLES = 0: the commit happens at the end of cycle T itself.
- DONE (cycle T+WAIT_CYCLES+1):
  - Stall = 0, Done = 1, RdValid = 1 only for loads.
  - ReqEn is ignored in this cycle because it is the still-held request being released.
  - Next state is IDLE.
- Timing: total Stall-high cycles per access = WAIT_CYCLES+1. Back-to-back accesses are accepted no earlier than cycle T+WAIT_CYCLES+2.
- Latched values are used throughout. Changes on ReqAddr, ReqData or ReqWr after cycle T have no effect on the access in flight.
- A load issued after a store to the same address returns the stored value. This needs no forwarding because accesses are serialized.
- rst during BUSY or DONE:
  - Return to IDLE and clear the pulses and RdData.
  - A store whose commit cycle has not yet been reached is dropped. Reset has priority over a commit in the same cycle.
- ReqEn = 0 in IDLE: no state change, Stall = 0, no pulses.
- Address wrap: with ADDR_BITS = 10, ReqAddr 16'h0400 aliases to word 0.

Test Plan:
- Reset then idle: rst high 2 cycles, ReqEn=0 → Stall=0, RdData=0000, RdValid=0, Done=0 on every cycle.
- Store then load, WAIT_CYCLES=2:
  - Store 16'hBEEF to 16'h0005 at cycle T → Stall high for T..T+2, Done at T+3, RdValid=0.
  - Load 16'h0005 at T+4 → Stall high T+4..T+6, RdValid and Done at T+7, RdData=BEEF held afterwards.
- WAIT_CYCLES=0 (separate build): load of a preloaded word 16'h1234 at address 3 → Stall high 1 cycle, RdValid the next cycle with RdData=1234.
- Input change mid-access: after acceptance, change ReqAddr to 16'h0006 and ReqData to 16'h0000 while Stall=1 → the original address/data are the ones written or read.
- Alias: store 16'hA5A5 to 16'h0401, then load 16'h0001 → RdData=A5A5.
- Reset mid-store: store 16'h7777 to address 9, assert rst in first BUSY cycle → FSM in IDLE next cycle, no Done; a later load of address 9 returns the prior contents, not 7777.
